// File: rtl/micro_op_sequencer_pkg.sv
// micro_op_sequencer_pkg: register map and decoder types shared by the micro-op sequencer
package RegMap;
  typedef enum logic [4:0] {
    r0, r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, r11, r12, r13, r14, r15,
    rtmp0, rtmp1, rflags, rnil
  } reg_id_t;
endpackage

package DecoderTypes;
  import RegMap::*;
  typedef enum logic [3:0] {
    m_nop, m_add, m_sub, m_and, m_or, m_xor, m_cpy, m_lea, m_ld, m_st,
    m_syscall, m_jmp, m_jz, m_jnz
  } micro_opcode_t;
  localparam micro_opcode_t M_JMIN = m_jmp;
  localparam micro_opcode_t M_JMAX = m_jnz;
  typedef enum logic [1:0] {OPD_NIL, OPD_REG, OPD_MEM, OPD_IMM} operand_kind_t;
  typedef struct packed {
    operand_kind_t kind;
    reg_id_t       base_reg;
    reg_id_t       index_reg;
  } operand_t;
  typedef struct packed {
    operand_t    operand0;
    operand_t    operand1;
    logic [1:0]  scale;
    logic [31:0] disp;
    logic [31:0] immediate;
    logic [31:0] rip_val;
  } fat_instruction_t;
  typedef struct packed {
    micro_opcode_t op;
    reg_id_t       src0;
    reg_id_t       src1;
    reg_id_t       dst;
    logic [31:0]   src0_val;
    logic [31:0]   src1_val;
    logic [31:0]   dst_val;
    logic [1:0]    scale;
    logic [31:0]   disp;
    logic [31:0]   immediate;
    logic [31:0]   rip_val;
  } micro_op_t;
  typedef enum logic [2:0] {S_IDLE, S_LEA, S_LOAD, S_OP, S_STORE} seq_state_t;
  // jumps and syscalls never touch memory and always expand to a single OP
  function automatic logic is_ctl(micro_opcode_t op);
    return (op >= M_JMIN && op <= M_JMAX) || op == m_syscall;
  endfunction
  function automatic seq_state_t first_state(fat_instruction_t inst, micro_opcode_t op);
    return (!is_ctl(op) && (inst.operand0.kind == OPD_MEM || inst.operand1.kind == OPD_MEM)) ? S_LEA : S_OP;
  endfunction
endpackage

// File: rtl/micro_op_sequencer_uop_build.sv
// micro_op_sequencer_uop_build: maps sequencer state plus held instruction to one micro op
module micro_op_sequencer_uop_build
  import RegMap::*;
  import DecoderTypes::*;
#(
  parameter reg_id_t TMP_ADDR = RegMap::rtmp0,
  parameter reg_id_t TMP_DATA = RegMap::rtmp1
) (
  input  seq_state_t       state,
  input  fat_instruction_t inst,
  input  micro_opcode_t    op,
  output micro_op_t        uop,
  output logic             last
);
  operand_t a, b;
  logic ctl, m0, m1, cpy;
  // operand classification; a memory opd0 takes precedence so a doubly-memory instruction ignores opd1
  always_comb begin
    a = inst.operand0;
    b = inst.operand1;
    ctl = is_ctl(op);
    m0 = !ctl && a.kind == OPD_MEM;
    m1 = !ctl && !m0 && b.kind == OPD_MEM;
    cpy = op == m_cpy;
  end
  // per-state register routing; pass-through fields are shared by every micro op
  always_comb begin
    uop = '0;
    uop.scale = inst.scale;
    uop.disp = inst.disp;
    uop.immediate = inst.immediate;
    uop.rip_val = inst.rip_val;
    last = 1'b0;
    case (state)
      S_LEA: begin
        uop.op = m_lea;
        uop.src0 = m0 ? a.base_reg : b.base_reg;
        uop.src1 = m0 ? a.index_reg : b.index_reg;
        uop.dst = TMP_ADDR;
      end
      S_LOAD: begin
        uop.op = m_ld;
        uop.src0 = TMP_ADDR;
        uop.src1 = rnil;
        uop.dst = cpy ? a.base_reg : TMP_DATA;
        last = cpy;
      end
      S_OP: begin
        uop.op = op;
        uop.src0 = m0 ? TMP_DATA : a.base_reg;
        uop.src1 = ctl ? (op == m_syscall ? rnil : rflags) : m0 ? b.base_reg : m1 ? TMP_DATA : b.kind == OPD_NIL ? rnil : b.base_reg;
        uop.dst = ctl ? rnil : m0 ? TMP_DATA : a.base_reg;
        last = !m0;
      end
      S_STORE: begin
        uop.op = m_st;
        uop.src0 = cpy ? b.base_reg : TMP_DATA;
        uop.src1 = TMP_ADDR;
        uop.dst = rnil;
        last = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/micro_op_sequencer.sv
// micro_op_sequencer: expands decoded instructions into lea/load/op/store micro-op sequences
module micro_op_sequencer
  import RegMap::*;
  import DecoderTypes::*;
#(
  parameter reg_id_t TMP_ADDR = RegMap::rtmp0,
  parameter reg_id_t TMP_DATA = RegMap::rtmp1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  fat_instruction_t in_inst,
  input  micro_opcode_t    in_uop_op,
  output logic             out_valid,
  input  logic             out_ready,
  output micro_op_t        out_uop,
  output logic             out_last,
  input  logic             flush
);
  seq_state_t state, step, nstate;
  fat_instruction_t inst_q, ninst;
  micro_opcode_t op_q, nop;
  micro_op_t nuop;
  logic nlast, rdy_en, in_fire, out_fire;
  assign out_fire = out_valid && out_ready;
  assign in_ready = rdy_en && !flush && (state == S_IDLE || (out_last && out_fire));
  assign in_fire = in_valid && in_ready;
  // next state and held instruction; a new accept replaces the finishing one with no bubble
  always_comb begin
    step = state == S_LEA ? ((op_q == m_cpy && inst_q.operand0.kind == OPD_MEM) ? S_STORE : S_LOAD) : state == S_LOAD ? S_OP : S_STORE;
    nstate = flush ? S_IDLE : in_fire ? first_state(in_inst, in_uop_op) : out_fire ? (out_last ? S_IDLE : step) : state;
    ninst = in_fire ? in_inst : inst_q;
    nop = in_fire ? in_uop_op : op_q;
  end
  micro_op_sequencer_uop_build #(
    .TMP_ADDR(TMP_ADDR),
    .TMP_DATA(TMP_DATA)
  ) uop_build (
    .state(nstate),
    .inst(ninst),
    .op(nop),
    .uop(nuop),
    .last(nlast)
  );
  // state and registered outputs; the micro op for the next state is built ahead and latched
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= S_IDLE;
      inst_q <= '0;
      op_q <= m_nop;
      rdy_en <= 1'b0;
      out_valid <= 1'b0;
      out_uop <= '0;
      out_last <= 1'b0;
    end else begin
      state <= nstate;
      inst_q <= ninst;
      op_q <= nop;
      rdy_en <= 1'b1;
      out_valid <= nstate != S_IDLE;
      out_uop <= nstate != S_IDLE ? nuop : '0;
      out_last <= nstate != S_IDLE && nlast;
    end
endmodule

// File: tb/tb_micro_op_sequencer.sv
// tb_micro_op_sequencer: scoreboard bench for the micro-op sequencer
module tb_micro_op_sequencer;
  import RegMap::*;
  import DecoderTypes::*;
  typedef struct packed {
    micro_op_t u;
    logic      last;
  } exp_t;
  logic clk = 1'b0, reset_n = 1'b1, in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic in_ready, out_valid, out_last;
  fat_instruction_t in_inst = '0;
  micro_opcode_t in_uop_op = m_nop;
  micro_op_t out_uop;
  int tests = 0, fails = 0, cyc = 0, acc_cyc = 0;
  exp_t exp_q[$];
  int hs_q[$];
  logic stall_p = 1'b0, flush_p = 1'b0, p_last = 1'b0;
  micro_op_t p_uop = '0;

  micro_op_sequencer dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_uop_op(in_uop_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_uop(out_uop), .out_last(out_last), .flush(flush)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic fat_instruction_t mki(operand_kind_t k0, reg_id_t b0, reg_id_t x0,
                                           operand_kind_t k1, reg_id_t b1, reg_id_t x1,
                                           logic [1:0] sc, logic [31:0] d);
    fat_instruction_t i;
    i.operand0 = '{k0, b0, x0};
    i.operand1 = '{k1, b1, x1};
    i.scale = sc;
    i.disp = d;
    i.immediate = d ^ 32'hA5A5_0000;
    i.rip_val = 32'h0040_1000 + d;
    return i;
  endfunction

  function automatic void push(fat_instruction_t i, micro_opcode_t o, reg_id_t s0, reg_id_t s1, reg_id_t d, logic l);
    exp_t e;
    e = '0;
    e.u.op = o;
    e.u.src0 = s0;
    e.u.src1 = s1;
    e.u.dst = d;
    e.u.scale = i.scale;
    e.u.disp = i.disp;
    e.u.immediate = i.immediate;
    e.u.rip_val = i.rip_val;
    e.last = l;
    exp_q.push_back(e);
  endfunction

  // reference expansion of one instruction into its expected micro ops
  function automatic void expand(fat_instruction_t i, micro_opcode_t o);
    operand_t a, b;
    a = i.operand0;
    b = i.operand1;
    if ((o >= M_JMIN && o <= M_JMAX) || o == m_syscall)
      push(i, o, a.base_reg, o == m_syscall ? rnil : rflags, rnil, 1'b1);
    else if (a.kind == OPD_MEM) begin
      push(i, m_lea, a.base_reg, a.index_reg, rtmp0, 1'b0);
      if (o == m_cpy) push(i, m_st, b.base_reg, rtmp0, rnil, 1'b1);
      else begin
        push(i, m_ld, rtmp0, rnil, rtmp1, 1'b0);
        push(i, o, rtmp1, b.base_reg, rtmp1, 1'b0);
        push(i, m_st, rtmp1, rtmp0, rnil, 1'b1);
      end
    end else if (b.kind == OPD_MEM) begin
      push(i, m_lea, b.base_reg, b.index_reg, rtmp0, 1'b0);
      if (o == m_cpy) push(i, m_ld, rtmp0, rnil, a.base_reg, 1'b1);
      else begin
        push(i, m_ld, rtmp0, rnil, rtmp1, 1'b0);
        push(i, o, a.base_reg, rtmp1, a.base_reg, 1'b1);
      end
    end else
      push(i, o, a.base_reg, b.kind == OPD_NIL ? rnil : b.base_reg, a.base_reg, 1'b1);
  endfunction

  // output monitor: pops the scoreboard on every handshake and checks stall stability
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && stall_p && !flush_p) begin
      tests++;
      if (!out_valid || out_uop !== p_uop || out_last !== p_last) begin
        fails++;
        $display("FAIL stall_stable: got valid=%b uop=%h last=%b, required valid=1 uop=%h last=%b", out_valid, out_uop, out_last, p_uop, p_last);
      end
    end
    if (reset_n && out_valid && out_ready) begin
      tests++;
      hs_q.push_back(cyc + 1);
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_uop: got uop=%h last=%b, required none", out_uop, out_last);
      end else begin
        e = exp_q.pop_front();
        if ({out_uop, out_last} !== e) begin
          fails++;
          $display("FAIL uop: got uop=%h last=%b, required uop=%h last=%b", out_uop, out_last, e.u, e.last);
        end
      end
    end
    stall_p = reset_n && out_valid && !out_ready;
    p_uop = out_uop;
    p_last = out_last;
    flush_p = flush;
  end

  task automatic send(fat_instruction_t i, micro_opcode_t o);
    logic done;
    done = 1'b0;
    in_inst = i;
    in_uop_op = o;
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        expand(i, o);
        acc_cyc = cyc + 1;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, required accept");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d uops outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string name, logic [255:0] got, logic [255:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    chk("reset_out_valid", 256'(out_valid), 256'd0);
    chk("reset_out_last", 256'(out_last), 256'd0);
    chk("reset_out_uop", 256'(out_uop), 256'd0);
    chk("reset_in_ready", 256'(in_ready), 256'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("in_ready_before_clock", 256'(in_ready), 256'd0);
    @(posedge clk);
    #1;
    chk("in_ready_after_release", 256'(in_ready), 256'd1);
  endtask

  task automatic test_reg_op();
    out_ready = 1'b1;
    hs_q.delete();
    send(mki(OPD_REG, r1, r0, OPD_REG, r2, r0, 2'd0, 32'd0), m_add);
    drain();
    chk("reg_latency", 256'(hs_q.size() == 1 ? hs_q[0] : -1), 256'(acc_cyc + 1));
    send(mki(OPD_REG, r7, r0, OPD_NIL, r0, r0, 2'd1, 32'd3), m_xor);
    drain();
  endtask

  task automatic test_mem_src();
    out_ready = 1'b1;
    hs_q.delete();
    send(mki(OPD_REG, r1, r0, OPD_MEM, r3, r4, 2'd2, 32'd8), m_add);
    drain();
    chk("mem_src_consecutive", 256'(hs_q.size() == 3 ? hs_q[2] - hs_q[0] : -1), 256'd2);
  endtask

  task automatic test_mem_dst_stall();
    out_ready = 1'b1;
    send(mki(OPD_MEM, r3, rnil, OPD_REG, r2, r0, 2'd0, 32'd0), m_add);
    for (int k = 0; k < 12; k++) begin
      out_ready = (k % 2) == 0;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    hs_q.delete();
    send(mki(OPD_REG, r5, r0, OPD_REG, r6, r0, 2'd0, 32'd1), m_sub);
    send(mki(OPD_REG, r7, r0, OPD_REG, r8, r0, 2'd0, 32'd2), m_and);
    drain();
    chk("b2b_reg_gap", 256'(hs_q.size() == 2 ? hs_q[1] - hs_q[0] : -1), 256'd1);
    hs_q.delete();
    send(mki(OPD_REG, r9, r0, OPD_MEM, r10, r11, 2'd3, 32'd4), m_or);
    send(mki(OPD_REG, r12, r0, OPD_REG, r13, r0, 2'd0, 32'd5), m_add);
    drain();
    chk("b2b_mem_gap", 256'(hs_q.size() == 4 ? hs_q[3] - hs_q[0] : -1), 256'd3);
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    send(mki(OPD_MEM, r3, r4, OPD_REG, r2, r0, 2'd1, 32'd12), m_add);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 256'(in_ready), 256'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_q.delete();
    chk("flush_out_valid", 256'(out_valid), 256'd0);
    out_ready = 1'b1;
    send(mki(OPD_REG, r14, r0, OPD_REG, r15, r0, 2'd0, 32'd6), m_sub);
    drain();
  endtask

  task automatic test_cpy_ctl_illegal();
    out_ready = 1'b1;
    send(mki(OPD_REG, r9, r0, OPD_MEM, r10, r11, 2'd3, 32'd16), m_cpy);
    send(mki(OPD_MEM, r12, rnil, OPD_REG, r13, r0, 2'd0, 32'd4), m_cpy);
    send(mki(OPD_REG, r5, r0, OPD_NIL, r0, r0, 2'd0, 32'd32), m_jz);
    send(mki(OPD_REG, r0, r0, OPD_NIL, r0, r0, 2'd0, 32'd0), m_syscall);
    send(mki(OPD_MEM, r3, r4, OPD_MEM, r6, r7, 2'd1, 32'd20), m_add);
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(mki(OPD_REG, r1, r0, OPD_REG, r2, r0, 2'd0, 32'd9), m_add);
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_reset_out_valid", 256'(out_valid), 256'd0);
    chk("mid_reset_out_uop", 256'(out_uop), 256'd0);
    chk("mid_reset_out_last", 256'(out_last), 256'd0);
    chk("mid_reset_in_ready", 256'(in_ready), 256'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_reset_in_ready_rise", 256'(in_ready), 256'd1);
    repeat (3) begin
      @(negedge clk);
      chk("mid_reset_no_output", 256'(out_valid), 256'd0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_reg_op();
    test_mem_src();
    test_mem_dst_stall();
    test_back_to_back();
    test_flush();
    test_cpy_ctl_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/micro_op_sequencer.md
MICRO_OP_SEQUENCER -- requirements
Module: micro_op_sequencer

Interface
REQ-001 SHALL have parameter TMP_ADDR, default RegMap::rtmp0, temp register that holds the effective address.
REQ-002 SHALL have parameter TMP_DATA, default RegMap::rtmp1, temp register that holds loaded data.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  a decoded instruction is offered.
REQ-006 in_ready  out  1  sequencer accepts in_inst this cycle.
REQ-007 in_inst  in  fat_instruction_t  decoded instruction.
REQ-008 in_uop_op  in  micro_opcode_t  base operation chosen by the decoder: ALU op, m_cpy, jump (M_JMIN..M_JMAX) or m_syscall.
REQ-009 out_valid  out  1  out_uop is valid.
REQ-010 out_ready  in  1  downstream accepts out_uop.
REQ-011 out_uop  out  micro_op_t  emitted micro op.
REQ-012 out_last  out  1  out_uop is the final micro op of its instruction.
REQ-013 flush  in  1  synchronous discard of the held instruction and any pending micro ops.

Function
REQ-014 Transfers SHALL occur only when valid and ready are both high; out_uop and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-015 FSM states SHALL be IDLE, LEA, LOAD, OP, STORE; an accepted instruction is registered and its first micro op is presented the next cycle.
REQ-016 Expansion by operand type (opd0/opd1 = in_inst.operand0/operand1):
 - jump or syscall: OP only; src0=opd0.base_reg, src1=rflags for jumps and rnil for syscall, dst=rnil.
 - no memory operand: OP(opd0.base, opd1.base or rnil if nil, opd0.base).
 - opd1 memory: LEA(opd1.base, opd1.index, TMP_ADDR) -> LOAD(TMP_ADDR, rnil, TMP_DATA) -> OP(opd0.base, TMP_DATA, opd0.base).
 - opd0 memory: LEA(opd0.base, opd0.index, TMP_ADDR) -> LOAD(TMP_ADDR, rnil, TMP_DATA) -> OP(TMP_DATA, opd1.base, TMP_DATA) -> STORE(TMP_DATA, TMP_ADDR, rnil).
 - m_cpy with opd1 memory: LEA -> LOAD writing opd0.base directly, 2 micro ops.
 - m_cpy with opd0 memory: LEA -> STORE(opd1.base, TMP_ADDR, rnil), 2 micro ops.
REQ-017 LEA, LOAD, STORE and OP SHALL emit m_lea, m_ld, m_st and in_uop_op respectively.
REQ-018 scale, disp, immediate and rip_val SHALL be copied unchanged into every micro op of the instruction; src0_val, src1_val and dst_val SHALL be zero.
REQ-019 The FSM SHALL advance one state per out handshake; out_last SHALL be 1 only on the final micro op.
REQ-020 in_ready SHALL be 1 in IDLE, or when out_last=1, out_valid=1 and out_ready=1 (back-to-back), so that issue has zero bubble between instructions.
REQ-021 flush SHALL force IDLE with out_valid=0 the next cycle, and in_ready SHALL be 0 in the flush cycle; flush wins over a simultaneous in or out handshake.
REQ-022 An instruction with both operands memory-typed is illegal; it SHALL be handled as the opd0-memory case and opd1 SHALL be ignored.

Reset
REQ-023 Assertion of reset_n=0 SHALL immediately force IDLE, out_valid=0, out_last=0, out_uop=0 and in_ready=0.
REQ-024 in_ready SHALL rise in the first clock after reset_n deasserts.
REQ-025 Reset mid-instruction SHALL discard that instruction without emitting further micro ops.

Structure
REQ-026 The FSM state enum, along with the rtmp0, rtmp1, rnil and rflags identifiers, SHALL reside in the shared packages (DecoderTypes and RegMap).
REQ-027 One sub-module, uop_build (combinational: state + held instruction -> micro_op_t, last), SHALL be used.

Verification
REQ-028 add r1,r2 with out_ready=1 -> one m_add(r1,r2,r1) one cycle after accept, out_last=1.
REQ-029 add r1,[r3+r4*4+8] -> m_lea(r3,r4,tmp0), m_ld(tmp0,rnil,tmp1), m_add(r1,tmp1,r1) on 3 consecutive cycles, scale=2, disp=8 on each.
REQ-030 add [r3],r2 with out_ready toggling 1,0,1,0 -> 4 micro ops lea/ld/add/st, each held stable while stalled, last only on m_st.
REQ-031 Two register instructions back-to-back -> outputs on consecutive cycles, no bubble.
REQ-032 flush during LOAD of a 4-uop instruction -> out_valid=0 next cycle, next accepted instruction emits correctly.
REQ-033 reset_n pulsed low in OP state -> outputs zero immediately, in_ready=1 one cycle after release.
